// File: rtl/bg_fetch_seq.sv
// Background fetch slot sequencer: walks x across the 264-dot fetch window and decodes per-mode slots.
// Define BG_FETCH_SEQ_MOSAIC_EN to build the horizontal mosaic counter; otherwise the strobe is tied high.
module bg_fetch_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       dot_en,
    input  logic       line_start,
    input  logic [2:0] bg_mode,
    input  logic [3:0] mosaic_size,
    output logic [8:0] x,
    output logic [3:0] fetch_map,
    output logic [3:0] fetch_data,
    output logic [2:0] fetch_data_num,
    output logic       active,
    output logic       newline,
    output logic       mosaic_pixel_strobe
);

    localparam logic [8:0] LAST_X = 9'd263;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_MAP,
        SLOT_DATA
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [1:0] bg;
        logic [2:0] num;
    } slot_t;

    state_t     state;
    logic [2:0] mode_q;
    logic [2:0] slot;
    slot_t      cur;

    function automatic slot_t mk(input kind_t kind, input logic [1:0] bg, input logic [2:0] num);
        slot_t s;
        s.kind = kind;
        s.bg   = bg;
        s.num  = num;
        return s;
    endfunction

    // A line_start always wins, even mid-line, so an aborted line never finishes its fetches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            x       <= 9'd0;
            newline <= 1'b0;
            mode_q  <= 3'd0;
        end else if (dot_en) begin
            if (line_start) begin
                state   <= FETCH;
                x       <= 9'd0;
                newline <= 1'b1;
                mode_q  <= bg_mode;
            end else begin
                newline <= 1'b0;
                if (state == FETCH) begin
                    if (x == LAST_X) begin
                        state <= IDLE;
                    end else begin
                        x <= x + 9'd1;
                    end
                end
            end
        end
    end

    assign active = (state == FETCH);
    assign slot   = x[2:0];

`ifdef BG_FETCH_SEQ_MOSAIC_EN
    logic [3:0] mosaic_cnt;
    logic [3:0] mosaic_size_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosaic_cnt    <= 4'd0;
            mosaic_size_q <= 4'd0;
        end else if (dot_en) begin
            if (line_start) begin
                mosaic_cnt    <= 4'd0;
                mosaic_size_q <= mosaic_size;
            end else if (state == FETCH) begin
                mosaic_cnt <= (mosaic_cnt == mosaic_size_q) ? 4'd0 : mosaic_cnt + 4'd1;
            end
        end
    end

    assign mosaic_pixel_strobe = (mosaic_cnt == 4'd0);
`else
    logic unused_mosaic_size;
    assign unused_mosaic_size  = ^mosaic_size;
    assign mosaic_pixel_strobe = 1'b1;
`endif

    // bg is zero-based (BG1 = 0); OPT fetches are BG3 map slots carrying a sub-fetch index.
    always_comb begin
        cur = mk(SLOT_IDLE, 2'd0, 3'd0);
        case (mode_q)
            3'd0: begin
                cur = mk(slot[0] ? SLOT_DATA : SLOT_MAP, slot[2:1], 3'd0);
            end
            3'd1: begin
                case (slot)
                    3'd0: cur = mk(SLOT_MAP,  2'd0, 3'd0);
                    3'd1: cur = mk(SLOT_DATA, 2'd0, 3'd0);
                    3'd2: cur = mk(SLOT_DATA, 2'd0, 3'd2);
                    3'd3: cur = mk(SLOT_MAP,  2'd1, 3'd0);
                    3'd4: cur = mk(SLOT_DATA, 2'd1, 3'd0);
                    3'd5: cur = mk(SLOT_DATA, 2'd1, 3'd2);
                    3'd6: cur = mk(SLOT_MAP,  2'd2, 3'd0);
                    default: cur = mk(SLOT_DATA, 2'd2, 3'd0);
                endcase
            end
            3'd2: begin
                case (slot)
                    3'd0: cur = mk(SLOT_MAP,  2'd2, 3'd0);
                    3'd1: cur = mk(SLOT_MAP,  2'd2, 3'd1);
                    3'd2: cur = mk(SLOT_MAP,  2'd0, 3'd0);
                    3'd3: cur = mk(SLOT_DATA, 2'd0, 3'd0);
                    3'd4: cur = mk(SLOT_DATA, 2'd0, 3'd2);
                    3'd5: cur = mk(SLOT_MAP,  2'd1, 3'd0);
                    3'd6: cur = mk(SLOT_DATA, 2'd1, 3'd0);
                    default: cur = mk(SLOT_DATA, 2'd1, 3'd2);
                endcase
            end
            3'd3: begin
                case (slot)
                    3'd0: cur = mk(SLOT_MAP,  2'd0, 3'd0);
                    3'd1: cur = mk(SLOT_DATA, 2'd0, 3'd0);
                    3'd2: cur = mk(SLOT_DATA, 2'd0, 3'd2);
                    3'd3: cur = mk(SLOT_DATA, 2'd0, 3'd4);
                    3'd4: cur = mk(SLOT_DATA, 2'd0, 3'd6);
                    3'd5: cur = mk(SLOT_MAP,  2'd1, 3'd0);
                    3'd6: cur = mk(SLOT_DATA, 2'd1, 3'd0);
                    default: cur = mk(SLOT_DATA, 2'd1, 3'd2);
                endcase
            end
            3'd4: begin
                case (slot)
                    3'd0: cur = mk(SLOT_MAP,  2'd2, 3'd0);
                    3'd1: cur = mk(SLOT_MAP,  2'd0, 3'd0);
                    3'd2: cur = mk(SLOT_DATA, 2'd0, 3'd0);
                    3'd3: cur = mk(SLOT_DATA, 2'd0, 3'd2);
                    3'd4: cur = mk(SLOT_DATA, 2'd0, 3'd4);
                    3'd5: cur = mk(SLOT_DATA, 2'd0, 3'd6);
                    3'd6: cur = mk(SLOT_MAP,  2'd1, 3'd0);
                    default: cur = mk(SLOT_DATA, 2'd1, 3'd0);
                endcase
            end
            3'd5: begin
                case (slot)
                    3'd0: cur = mk(SLOT_MAP,  2'd0, 3'd0);
                    3'd1: cur = mk(SLOT_DATA, 2'd0, 3'd0);
                    3'd2: cur = mk(SLOT_DATA, 2'd0, 3'd1);
                    3'd3: cur = mk(SLOT_DATA, 2'd0, 3'd2);
                    3'd4: cur = mk(SLOT_DATA, 2'd0, 3'd3);
                    3'd5: cur = mk(SLOT_MAP,  2'd1, 3'd0);
                    3'd6: cur = mk(SLOT_DATA, 2'd1, 3'd0);
                    default: cur = mk(SLOT_DATA, 2'd1, 3'd1);
                endcase
            end
            3'd6: begin
                case (slot)
                    3'd0: cur = mk(SLOT_MAP,  2'd2, 3'd0);
                    3'd1: cur = mk(SLOT_MAP,  2'd2, 3'd1);
                    3'd2: cur = mk(SLOT_MAP,  2'd0, 3'd0);
                    3'd3: cur = mk(SLOT_DATA, 2'd0, 3'd0);
                    3'd4: cur = mk(SLOT_DATA, 2'd0, 3'd1);
                    3'd5: cur = mk(SLOT_DATA, 2'd0, 3'd2);
                    3'd6: cur = mk(SLOT_DATA, 2'd0, 3'd3);
                    default: cur = mk(SLOT_IDLE, 2'd0, 3'd0);
                endcase
            end
            default: cur = mk(SLOT_IDLE, 2'd0, 3'd0);
        endcase
    end

    always_comb begin
        fetch_map      = 4'd0;
        fetch_data     = 4'd0;
        fetch_data_num = 3'd0;
        if (active) begin
            case (cur.kind)
                SLOT_MAP: begin
                    fetch_map[cur.bg] = 1'b1;
                    fetch_data_num    = cur.num;
                end
                SLOT_DATA: begin
                    fetch_data[cur.bg] = 1'b1;
                    fetch_data_num     = cur.num;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bg_fetch_seq.sv
// Self-checking bench for bg_fetch_seq: a behavioural line model feeds a per-dot scoreboard,
// and scenario tasks add targeted checks on slot patterns, line length, aborts, mosaic and reset.
module tb_bg_fetch_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       dot_en;
    logic       line_start;
    logic [2:0] bg_mode;
    logic [3:0] mosaic_size;
    logic [8:0] x;
    logic [3:0] fetch_map;
    logic [3:0] fetch_data;
    logic [2:0] fetch_data_num;
    logic       active;
    logic       newline;
    logic       mosaic_pixel_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [8:0] x;
        logic       active;
        logic       newline;
        logic [3:0] map;
        logic [3:0] data;
        logic [2:0] num;
        logic       strobe;
    } obs_t;

    obs_t sb[$];

    // Expected {map, data, num} per mode and slot, filled from the human-readable slot table.
    logic [10:0] tbl [8][8];

    int   m_x;
    bit   m_active;
    bit   m_newline;
    int   m_mode;
    int   m_msize;
    int   m_mcnt;

    always #5 clk = ~clk;

    bg_fetch_seq dut (
        .clk                 (clk),
        .reset               (reset),
        .dot_en              (dot_en),
        .line_start          (line_start),
        .bg_mode             (bg_mode),
        .mosaic_size         (mosaic_size),
        .x                   (x),
        .fetch_map           (fetch_map),
        .fetch_data          (fetch_data),
        .fetch_data_num      (fetch_data_num),
        .active              (active),
        .newline             (newline),
        .mosaic_pixel_strobe (mosaic_pixel_strobe)
    );

    function automatic logic [10:0] m(input int bg);
        logic [3:0] b;
        b = 4'(1 << (bg - 1));
        return {b, 4'd0, 3'd0};
    endfunction

    function automatic logic [10:0] d(input int bg, input int num);
        logic [3:0] b;
        b = 4'(1 << (bg - 1));
        return {4'd0, b, 3'(num)};
    endfunction

    function automatic logic [10:0] o(input int num);
        return {4'b0100, 4'd0, 3'(num)};
    endfunction

    task automatic set_row(input int md, input logic [10:0] a0, input logic [10:0] a1,
                           input logic [10:0] a2, input logic [10:0] a3, input logic [10:0] a4,
                           input logic [10:0] a5, input logic [10:0] a6, input logic [10:0] a7);
        tbl[md][0] = a0; tbl[md][1] = a1; tbl[md][2] = a2; tbl[md][3] = a3;
        tbl[md][4] = a4; tbl[md][5] = a5; tbl[md][6] = a6; tbl[md][7] = a7;
    endtask

    task automatic init_table();
        set_row(0, m(1), d(1,0), m(2), d(2,0), m(3), d(3,0), m(4), d(4,0));
        set_row(1, m(1), d(1,0), d(1,2), m(2), d(2,0), d(2,2), m(3), d(3,0));
        set_row(2, o(0), o(1), m(1), d(1,0), d(1,2), m(2), d(2,0), d(2,2));
        set_row(3, m(1), d(1,0), d(1,2), d(1,4), d(1,6), m(2), d(2,0), d(2,2));
        set_row(4, o(0), m(1), d(1,0), d(1,2), d(1,4), d(1,6), m(2), d(2,0));
        set_row(5, m(1), d(1,0), d(1,1), d(1,2), d(1,3), m(2), d(2,0), d(2,1));
        set_row(6, o(0), o(1), m(1), d(1,0), d(1,1), d(1,2), d(1,3), 11'd0);
        set_row(7, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0);
    endtask

    task automatic model_reset();
        m_x = 0; m_active = 0; m_newline = 0; m_mode = 0; m_msize = 0; m_mcnt = 0;
    endtask

    task automatic model_step(input bit ls);
        if (ls) begin
            m_active = 1; m_x = 0; m_newline = 1; m_mcnt = 0;
            m_mode = int'(bg_mode); m_msize = int'(mosaic_size);
        end else begin
            m_newline = 0;
            if (m_active) begin
                if (m_x == 263) m_active = 0;
                else m_x = m_x + 1;
                m_mcnt = (m_mcnt == m_msize) ? 0 : m_mcnt + 1;
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t e;
        logic [10:0] f;
        f = m_active ? tbl[m_mode][m_x % 8] : 11'd0;
        e.x       = 9'(m_x);
        e.active  = m_active;
        e.newline = m_newline;
        e.map     = f[10:7];
        e.data    = f[6:3];
        e.num     = f[2:0];
`ifdef BG_FETCH_SEQ_MOSAIC_EN
        e.strobe  = (m_mcnt == 0);
`else
        e.strobe  = 1'b1;
`endif
        return e;
    endfunction

    // One clock: drive inputs on the falling edge, record the model expectation at the rising edge,
    // then pop and compare against the DUT shortly after the edge.
    task automatic dot(input bit ls, input bit en = 1'b1);
        obs_t e;
        obs_t got;
        @(negedge clk);
        line_start = ls;
        dot_en     = en;
        @(posedge clk);
        if (en) model_step(ls);
        sb.push_back(model_obs());
        #1;
        got = {x, active, newline, fetch_map, fetch_data, fetch_data_num, mosaic_pixel_strobe};
        e   = sb.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("[TB] FAIL sb_dot: got x=%0d act=%b nl=%b map=%b data=%b num=%0d strb=%b, expected x=%0d act=%b nl=%b map=%b data=%b num=%0d strb=%b",
                     got.x, got.active, got.newline, got.map, got.data, got.num, got.strobe,
                     e.x, e.active, e.newline, e.map, e.data, e.num, e.strobe);
        end
        n_checks++;
        if ($countones({fetch_map, fetch_data}) > 1) begin
            n_fail++;
            $display("[TB] FAIL one_hot: got map=%b data=%b, expected at most one bit set", fetch_map, fetch_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; dot_en = 1'b0; line_start = 1'b0; bg_mode = 3'd1; mosaic_size = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({x, active, newline, fetch_map, fetch_data, fetch_data_num} !== 20'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got x=%0d act=%b nl=%b map=%b data=%b num=%0d, expected all zero",
                     x, active, newline, fetch_map, fetch_data, fetch_data_num);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) dot(1'b0);
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got active=%b, expected 0", active);
        end
    endtask

    task automatic test_mode1_slots();
        logic [10:0] want [8];
        want[0] = 11'b0001_0000_000; want[1] = 11'b0000_0001_000;
        want[2] = 11'b0000_0001_010; want[3] = 11'b0010_0000_000;
        want[4] = 11'b0000_0010_000; want[5] = 11'b0000_0010_010;
        want[6] = 11'b0100_0000_000; want[7] = 11'b0000_0100_000;
        bg_mode = 3'd1;
        for (int i = 0; i < 8; i++) begin
            dot(i == 0);
            n_checks++;
            if ({fetch_map, fetch_data, fetch_data_num} !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL mode1_slot%0d: got map=%b data=%b num=%0d, expected %b", i,
                         fetch_map, fetch_data, fetch_data_num, want[i]);
            end
        end
    endtask

    task automatic test_full_line_mode3();
        int maps = 0;
        int datas = 0;
        bg_mode = 3'd3;
        for (int i = 0; i < 264; i++) begin
            dot(i == 0);
            if (fetch_map[0]) maps++;
            if (fetch_data[0]) datas++;
        end
        n_checks++;
        if (maps != 33) begin
            n_fail++;
            $display("[TB] FAIL bg1_map_count: got %0d, expected 33", maps);
        end
        n_checks++;
        if (datas != 132) begin
            n_fail++;
            $display("[TB] FAIL bg1_data_count: got %0d, expected 132", datas);
        end
        dot(1'b0);
        n_checks++;
        if (active !== 1'b0 || x !== 9'd263) begin
            n_fail++;
            $display("[TB] FAIL line_end: got active=%b x=%0d, expected active=0 x=263", active, x);
        end
    endtask

    task automatic test_mode_change();
        int fetches = 0;
        bg_mode = 3'd1;
        dot(1'b1);
        for (int i = 1; i <= 263; i++) begin
            if (i == 100) bg_mode = 3'd7;
            dot(1'b0);
        end
        n_checks++;
        if (fetch_data !== 4'b0100 || fetch_data_num !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL mode_hold_x263: got data=%b num=%0d, expected data=0100 num=0", fetch_data, fetch_data_num);
        end
        dot(1'b0);
        for (int i = 0; i < 264; i++) begin
            dot(i == 0);
            fetches += $countones({fetch_map, fetch_data});
        end
        n_checks++;
        if (fetches != 0) begin
            n_fail++;
            $display("[TB] FAIL mode7_line: got %0d fetches, expected 0", fetches);
        end
    endtask

    task automatic test_abort();
        bg_mode = 3'd0;
        dot(1'b1);
        for (int i = 1; i <= 150; i++) dot(1'b0);
        dot(1'b1);
        n_checks++;
        if (x !== 9'd0 || newline !== 1'b1 || fetch_map !== 4'b0001 || fetch_data !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL abort_restart: got x=%0d nl=%b map=%b data=%b, expected x=0 nl=1 map=0001 data=0000",
                     x, newline, fetch_map, fetch_data);
        end
        dot(1'b0);
        n_checks++;
        if (newline !== 1'b0 || fetch_data !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL abort_slot1: got nl=%b data=%b, expected nl=0 data=0001", newline, fetch_data);
        end
    endtask

    task automatic test_all_modes();
        for (int md = 0; md < 8; md++) begin
            bg_mode = 3'(md);
            for (int i = 0; i < 17; i++) dot(i == 0);
        end
    endtask

    task automatic test_mosaic();
        logic [8:0] x_hold;
        bit         want;
        bg_mode = 3'd1; mosaic_size = 4'd3;
        dot(1'b1);
        for (int i = 1; i <= 5; i++) dot(1'b0);
        x_hold = x;
        for (int i = 0; i < 5; i++) dot(1'b1, 1'b0);
        n_checks++;
        if (x !== x_hold || x !== 9'd5) begin
            n_fail++;
            $display("[TB] FAIL dot_en_hold: got x=%0d, expected 5", x);
        end
        for (int i = 6; i <= 20; i++) begin
            if (i == 10) mosaic_size = 4'd0;
            dot(1'b0);
`ifdef BG_FETCH_SEQ_MOSAIC_EN
            want = (i % 4 == 0);
`else
            want = 1'b1;
`endif
            n_checks++;
            if (mosaic_pixel_strobe !== want) begin
                n_fail++;
                $display("[TB] FAIL mosaic_x%0d: got strobe=%b, expected %b", i, mosaic_pixel_strobe, want);
            end
        end
        mosaic_size = 4'd0;
        for (int i = 0; i < 6; i++) dot(i == 0);
    endtask

    task automatic test_reset_midline();
        int fetches = 0;
        bg_mode = 3'd1;
        dot(1'b1);
        for (int i = 1; i <= 40; i++) dot(1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({x, active, newline, fetch_map, fetch_data, fetch_data_num} !== 20'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got x=%0d act=%b nl=%b map=%b data=%b num=%0d, expected all zero",
                     x, active, newline, fetch_map, fetch_data, fetch_data_num);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dot(1'b0);
            fetches += $countones({fetch_map, fetch_data});
        end
        n_checks++;
        if (fetches != 0) begin
            n_fail++;
            $display("[TB] FAIL no_fetch_after_reset: got %0d fetches, expected 0", fetches);
        end
        dot(1'b1);
        n_checks++;
        if (fetch_map !== 4'b0001 || active !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL restart_after_reset: got map=%b act=%b, expected map=0001 act=1", fetch_map, active);
        end
    endtask

    initial begin
        init_table();
        test_reset();
        test_mode1_slots();
        test_full_line_mode3();
        test_mode_change();
        test_abort();
        test_all_modes();
        test_mosaic();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_fetch_seq.md
BG_FETCH_SEQ -- requirements
Module: bg_fetch_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: master PPU clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port dot_en, input, 1 bit: dot strobe; state advances only on clk edges with dot_en=1.
REQ-004 SHALL have port line_start, input, 1 bit: start of the fetch window for the current scanline; sampled only when dot_en=1.
REQ-005 SHALL have port bg_mode, input, 3 bits: BG mode 0-7, latched at line start.
REQ-006 SHALL have port mosaic_size, input, 4 bits: horizontal mosaic block size minus one.
REQ-007 SHALL have port x, output, 9 bits: next dot to fetch, 0-263; drives the x input of every bg instance.
REQ-008 SHALL have port fetch_map, output, 4 bits: one bit per BG1-BG4; asserted for a tilemap or OPT fetch slot.
REQ-009 SHALL have port fetch_data, output, 4 bits: one bit per BG1-BG4; asserted for a character-data fetch slot.
REQ-010 SHALL have port fetch_data_num, output, 3 bits: sub-fetch index shared by all BGs, per the slot table.
REQ-011 SHALL have port active, output, 1 bit: high while the fetch window runs.
REQ-012 SHALL have port newline, output, 1 bit: one-dot pulse at line start.
REQ-013 SHALL have port mosaic_pixel_strobe, output, 1 bit: first dot of each horizontal mosaic block.

Function
REQ-014 SHALL define slot = x[2:0], giving 33 groups of 8 slots per line (x 0-263).
REQ-015 SHALL, on a dot with line_start=1: set active=1, x=0, newline=1, mosaic counter=0, and latch bg_mode into mode_q.
REQ-016 SHALL, on a dot with active=1 and line_start=0: increment x; newline=0.
REQ-017 SHALL, on a dot where x=263: clear active and hold x at 263.
REQ-018 SHALL honour line_start while active=1: restart at x=0; no fetch from the aborted line is completed.
REQ-019 SHALL drive fetch_map, fetch_data and fetch_data_num combinationally from mode_q and slot, gated by active.
REQ-020 SHALL drive fetch_data_num=0 in map-only and idle slots.
REQ-021 SHALL use this slot table (M=map, D=data with fetch_data_num, O=BG3 map with fetch_data_num):
- Mode 0: M1 D1:0 M2 D2:0 M3 D3:0 M4 D4:0
- Mode 1: M1 D1:0 D1:2 M2 D2:0 D2:2 M3 D3:0
- Mode 2: O:0 O:1 M1 D1:0 D1:2 M2 D2:0 D2:2
- Mode 3: M1 D1:0 D1:2 D1:4 D1:6 M2 D2:0 D2:2
- Mode 4: O:0 M1 D1:0 D1:2 D1:4 D1:6 M2 D2:0
- Mode 5: M1 D1:0 D1:1 D1:2 D1:3 M2 D2:0 D2:1
- Mode 6: O:0 O:1 M1 D1:0 D1:1 D1:2 D1:3 idle
- Mode 7: idle in all slots.
REQ-022 SHALL never assert more than one bit in total across fetch_map and fetch_data in any dot.
REQ-023 SHALL ignore a bg_mode change mid-line; the change applies from the next line_start.
REQ-024 SHALL, when dot_en=0, hold all registers; combinational outputs stay stable.
REQ-025 SHALL count the mosaic counter 0..mosaic_size, then wrap to 0, on each active dot.
REQ-026 SHALL assert mosaic_pixel_strobe while the mosaic counter is 0; mosaic_size=0 gives strobe=1 on every dot.
REQ-027 SHALL sample mosaic_size at line start; a change mid-line is ignored.

Reset
REQ-028 SHALL, while reset=1: x=0, active=0, newline=0, mode_q=0, mosaic counter=0; therefore fetch_map=0, fetch_data=0, fetch_data_num=0.
REQ-029 SHALL, after reset is released, issue no fetches until the first line_start.

Configuration
REQ-030 SHALL compile the mosaic counter only when BG_FETCH_SEQ_MOSAIC_EN is defined.
REQ-031 SHALL, without BG_FETCH_SEQ_MOSAIC_EN, tie mosaic_pixel_strobe to 1 and ignore mosaic_size.

Verification
REQ-032 SHALL verify: mode 1, line_start, 8 dots -> slots 0-7 give fetch_map=0001, fetch_data=0001 (num 0), 0001 (num 2), map 0010, data 0010 (num 0), 0010 (num 2), map 0100, data 0100 (num 0).
REQ-033 SHALL verify: mode 3, 264 dots -> exactly 33 BG1 map fetches and 132 BG1 data fetches; active falls after x=263.
REQ-034 SHALL verify: mode changes from 1 to 7 at x=100 -> mode 1 pattern continues to 263; the next line issues no fetches.
REQ-035 SHALL verify: line_start at x=150 -> x=0 and newline=1 on the next dot; the slot-0 pattern restarts.
REQ-036 SHALL verify: mosaic_size=3 -> strobe at x=0, 4, 8, ...; with dot_en low for 5 clocks at x=5, the strobe phase is unchanged.
REQ-037 SHALL verify: reset asserted at x=40 -> all outputs 0 immediately; no fetch until the next line_start.
